// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: default pixel format (signed Q2.14),
// window geometry defaults, the window element index function used by both
// the window generator and the convolution stage, and the generator FSM states.
package cnn_pkg;

  localparam int Q_INT_BITS          = 2;
  localparam int Q_FRAC_BITS         = 14;
  localparam int DEFAULT_DATA_WIDTH  = Q_INT_BITS + Q_FRAC_BITS;
  localparam int DEFAULT_KERNEL_SIZE = 5;

  typedef enum logic {
    FILL   = 1'b0,
    ACTIVE = 1'b1
  } win_state_e;

  // Flattened window element index; row 0 is the top line, col 0 the leftmost pixel.
  function automatic int win_idx(input int row, input int col,
                                 input int k = DEFAULT_KERNEL_SIZE);
    return row * k + col;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Stream interface between the pixel source, the window generator and the
// convolution stage.
//   pixel_in/pixel_valid/pixel_ready         raster-order pixel stream (into generator)
//   window_out/window_valid/window_ready     flattened KxK window stream (out of generator)
//   frame_done                               pulse after the last pixel of a frame
//   window_first/window_last                 only with WINDOW_GEN_FRAME_FLAGS_EN
// master = source/consumer side, slave = window generator.
interface conv_window_gen_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5
) ();

  logic [DATA_WIDTH-1:0]                        pixel_in;
  logic                                         pixel_valid;
  logic                                         pixel_ready;
  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window_out;
  logic                                         window_valid;
  logic                                         window_ready;
  logic                                         frame_done;
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
  logic                                         window_first;
  logic                                         window_last;
`endif

  modport master (
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
    input  window_first,
    input  window_last,
`endif
    output pixel_in,
    output pixel_valid,
    input  pixel_ready,
    input  window_out,
    input  window_valid,
    output window_ready,
    input  frame_done
  );

  modport slave (
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
    output window_first,
    output window_last,
`endif
    input  pixel_in,
    input  pixel_valid,
    output pixel_ready,
    output window_out,
    output window_valid,
    input  window_ready,
    output frame_done
  );

endinterface

// File: rtl/line_buffer.sv
// One image line of delay: a DEPTH-deep shift register advanced only when en
// is high, so dout is the sample written DEPTH enabled cycles earlier.
// Contents are deliberately not reset; the generator never uses them before
// they have been refilled.
//   clock  rising-edge clock
//   en     shift enable (pixel accepted)
//   din    sample in
//   dout   sample from one line earlier
module line_buffer #(
  parameter int DEPTH      = 28,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Convolution window generator: takes a raster-order pixel stream, keeps
// KERNEL_SIZE-1 lines in chained line buffers and emits one flattened KxK
// window per valid output position (no padding, stride 1).
//   clock, reset_n   clock and asynchronous active-low reset
//   bus (slave)      pixel stream in, window stream out, frame_done pulse
// Optional macro WINDOW_GEN_FRAME_FLAGS_EN adds window_first/window_last.
//
// state  | meaning
// FILL   | rows 0..K-2 of the frame: lines are buffered, no windows produced
// ACTIVE | rows K-1..H-1: windows produced for columns K-1..W-1
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int KERNEL_SIZE  = DEFAULT_KERNEL_SIZE,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28
) (
  input logic              clock,
  input logic              reset_n,
  conv_window_gen_if.slave bus
);

  localparam int K  = KERNEL_SIZE;
  localparam int WW = DATA_WIDTH * K * K;
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);

  localparam logic [CW-1:0] COL_LAST     = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] COL_WIN0     = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMAGE_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_WIN0     = RW'(K - 1);
  localparam logic [RW-1:0] ROW_FILL_END = RW'(K - 2);

  win_state_e state_q, state_d;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          accept;
  logic          line_end;
  logic          last_px;
  logic          load_win;

  logic [DATA_WIDTH-1:0] lb_in   [K-1];
  logic [DATA_WIDTH-1:0] lb_out  [K-1];
  logic [DATA_WIDTH-1:0] col_new [K];
  logic [DATA_WIDTH-1:0] win_q   [K][K];
  logic [DATA_WIDTH-1:0] win_d   [K][K];
  logic [WW-1:0]         win_flat;

  logic [WW-1:0] win_out_q;
  logic          win_valid_q;
  logic          frame_done_q;

  assign accept   = bus.pixel_valid && bus.pixel_ready;
  assign line_end = (col_q == COL_LAST);
  assign last_px  = accept && line_end && (row_q == ROW_LAST);

  assign bus.pixel_ready  = !(win_valid_q && !bus.window_ready);
  assign bus.window_out   = win_out_q;
  assign bus.window_valid = win_valid_q;
  assign bus.frame_done   = frame_done_q;

  // Line buffer chain: buffer 0 holds the previous line, buffer K-2 the oldest.
  assign lb_in[0] = bus.pixel_in;
  for (genvar i = 1; i < K - 1; i++) begin : g_lb_chain
    assign lb_in[i] = lb_out[i-1];
  end

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    line_buffer #(
      .DEPTH      (IMAGE_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buffer (
      .clock (clock),
      .en    (accept),
      .din   (lb_in[i]),
      .dout  (lb_out[i])
    );
  end

  // Incoming column, top to bottom: oldest line first, live pixel last.
  for (genvar r = 0; r < K - 1; r++) begin : g_col
    assign col_new[r] = lb_out[K-2-r];
  end
  assign col_new[K-1] = bus.pixel_in;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][K-1] = col_new[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[DATA_WIDTH*win_idx(r, c, K) +: DATA_WIDTH] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Columns 0..K-2 would straddle the line wrap, so only col >= K-1 loads a window.
  always_comb begin
    state_d  = state_q;
    load_win = 1'b0;
    case (state_q)
      FILL: begin
        if (accept && line_end && (row_q == ROW_FILL_END)) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        load_win = accept && (col_q >= COL_WIN0);
        if (last_px) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (line_end) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win_q <= win_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_px;
      if (load_win) begin
        win_out_q   <= win_flat;
        win_valid_q <= 1'b1;
      end else if (bus.window_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

`ifdef WINDOW_GEN_FRAME_FLAGS_EN
  logic first_q;
  logic last_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_win) begin
      first_q <= (row_q == ROW_WIN0) && (col_q == COL_WIN0);
      last_q  <= last_px;
    end
  end

  assign bus.window_first = first_q;
  assign bus.window_last  = last_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

  localparam int K  = 3;
  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WW = DW * K * K;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  logic clock;
  logic reset_n;

  conv_window_gen_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) bus ();

  conv_window_gen #(
    .KERNEL_SIZE  (K),
    .DATA_WIDTH   (DW),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [WW-1:0] win_log [$];
  logic          fd_log  [$];
  int            pix_at  [$];
  logic [DW-1:0] pix_log [$];
  logic          first_log [$];
  logic          last_log  [$];
  int            pix_cnt = 0;
  int            fd_cnt  = 0;

  int first_win [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int last_win  [9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
  int f2_win    [9] = '{100, 101, 102, 105, 106, 107, 110, 111, 112};

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack9(input int v [9]);
    logic [WW-1:0] w = '0;
    for (int i = 0; i < K * K; i++) w[DW*i +: DW] = DW'(v[i]);
    return w;
  endfunction

  // Expected window n of a frame whose first pixel value is base.
  function automatic logic [WW-1:0] exp_win(input int base, input int n);
    logic [WW-1:0] w = '0;
    int r0 = n / (W - K + 1);
    int c0 = n % (W - K + 1);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[DW*(r*K+c) +: DW] = DW'(base + (r0 + r) * W + c0 + c);
    return w;
  endfunction

  function automatic logic [WW-1:0] got_win(input int n);
    return (n < win_log.size()) ? win_log[n] : '1;
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (bus.window_valid && bus.window_ready) begin
          win_log.push_back(bus.window_out);
          fd_log.push_back(bus.frame_done);
          pix_at.push_back(pix_cnt);
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
          first_log.push_back(bus.window_first);
          last_log.push_back(bus.window_last);
`endif
        end
        if (bus.frame_done) fd_cnt++;
        if (bus.pixel_valid && bus.pixel_ready) begin
          pix_cnt++;
          pix_log.push_back(bus.pixel_in);
        end
      end
    end
  end

  task automatic clear_logs();
    win_log.delete(); fd_log.delete(); pix_at.delete(); pix_log.delete();
    first_log.delete(); last_log.delete();
    pix_cnt = 0;
    fd_cnt  = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [DW-1:0] v);
    int n = 0;
    bus.pixel_in    = v;
    bus.pixel_valid = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.pixel_ready && n < 200);
    if (!bus.pixel_ready) begin
      chk("push_timeout", WW'(bus.pixel_ready), WW'(1));
      $display("FAIL push_timeout got=stalled exp=accepted");
      $fatal(1, "pixel stream stalled");
    end
    @(posedge clock);
    #1;
    bus.pixel_valid = 1'b0;
  endtask

  task automatic run_frame(input int base);
    for (int i = 0; i < W * H; i++) push(DW'(base + i));
  endtask

  task automatic drain();
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic check_windows(input string tag, input int nfr, input int base2);
    chk({tag, "_count"}, WW'(win_log.size()), WW'(NWIN * nfr));
    for (int i = 0; i < NWIN * nfr; i++)
      chk($sformatf("%s_win%0d", tag, i), got_win(i),
          (i < NWIN) ? exp_win(0, i) : exp_win(base2, i - NWIN));
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.pixel_in     = '0;
    bus.pixel_valid  = 1'b0;
    bus.window_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_valid", WW'(bus.window_valid), WW'(0));
    chk("rst_out", bus.window_out, '0);
    chk("rst_fd", WW'(bus.frame_done), WW'(0));
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_ready", WW'(bus.pixel_ready), WW'(1));

    // Single frame at full rate
    clear_logs();
    run_frame(0);
    drain();
    check_windows("s1", 1, 0);
    chk("s1_first", got_win(0), pack9(first_win));
    chk("s1_last", got_win(NWIN - 1), pack9(last_win));
    chk("s1_latency", WW'((pix_at.size() > 0) ? pix_at[0] : -1), WW'(13));
    chk("s1_fd_cnt", WW'(fd_cnt), WW'(1));
    chk("s1_fd_last", WW'((fd_log.size() == NWIN) ? fd_log[NWIN-1] : 1'b0), WW'(1));
    chk("s1_fd_first", WW'((fd_log.size() > 0) ? fd_log[0] : 1'b1), WW'(0));
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
    begin
      int nf = 0;
      int nl = 0;
      foreach (first_log[i]) nf += int'(first_log[i]);
      foreach (last_log[i]) nl += int'(last_log[i]);
      chk("flag_first0", WW'((first_log.size() > 0) ? first_log[0] : 1'b0), WW'(1));
      chk("flag_last5", WW'((last_log.size() == NWIN) ? last_log[NWIN-1] : 1'b0), WW'(1));
      chk("flag_first_cnt", WW'(nf), WW'(1));
      chk("flag_last_cnt", WW'(nl), WW'(1));
    end
`endif

    // Consumer stall after the first window
    clear_logs();
    for (int i = 0; i <= 12; i++) push(DW'(i));
    bus.window_ready = 1'b0;
    bus.pixel_in     = DW'(13);
    bus.pixel_valid  = 1'b1;
    repeat (4) @(negedge clock);
    chk("stall_ready", WW'(bus.pixel_ready), WW'(0));
    chk("stall_valid", WW'(bus.window_valid), WW'(1));
    chk("stall_hold", bus.window_out, pack9(first_win));
    @(posedge clock);
    #1;
    bus.window_ready = 1'b1;
    for (int i = 13; i < W * H; i++) push(DW'(i));
    drain();
    check_windows("s2", 1, 0);
    begin
      int errs = 0;
      foreach (pix_log[i]) if (pix_log[i] != DW'(i)) errs++;
      chk("s2_pix_cnt", WW'(pix_log.size()), WW'(W * H));
      chk("s2_pix_seq", WW'(errs), WW'(0));
    end

    // Two frames back to back
    clear_logs();
    run_frame(0);
    run_frame(100);
    drain();
    check_windows("s3", 2, 100);
    chk("s3_f2_first", got_win(NWIN), pack9(f2_win));
    chk("s3_fd_cnt", WW'(fd_cnt), WW'(2));

    // Reset in the middle of a frame
    clear_logs();
    for (int i = 0; i <= 14; i++) push(DW'(i));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", WW'(bus.window_valid), WW'(0));
    chk("mid_rst_fd", WW'(bus.frame_done), WW'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    clear_logs();
    run_frame(0);
    drain();
    check_windows("s4", 1, 0);
    chk("s4_fd_cnt", WW'(fd_cnt), WW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
